lab4_cpu_oci_dct_packer: RTL and testbench

LAB4_CPU_OCI_DCT_PACKER -- requirements
Module: lab4_cpu_oci_dct_packer

---
 rtl/lab4_cpu_oci_dct_pkg.sv | 16 +
 rtl/lab4_cpu_oci_dct_packer_if.sv | 23 ++
 rtl/lab4_cpu_oci_dct_out_reg.sv | 34 +++
 rtl/lab4_cpu_oci_dct_packer.sv | 121 ++++++++++++
 tb/tb_lab4_cpu_oci_dct_packer.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lab4_cpu_oci_dct_pkg.sv
// Shared widths and FSM encoding for the OCI DCT trace-atom packer.
package lab4_cpu_oci_dct_pkg;

    localparam int DCT_ATOM_W    = 2;
    localparam int DCT_MAX_ATOMS = 15;
    localparam int DCT_BUF_W     = 30;
    localparam int DCT_CNT_W     = 4;

    typedef enum logic [1:0] {
        COLLECT,
        STALL,
        DRAIN,
        ENDED
    } dct_state_e;

endpackage

// File: rtl/lab4_cpu_oci_dct_packer_if.sv
// Atom input and packed-frame output handshakes of the DCT packer.
interface lab4_cpu_oci_dct_packer_if;
    import lab4_cpu_oci_dct_pkg::*;

    logic                  atom_valid;
    logic [DCT_ATOM_W-1:0] atom;
    logic                  atom_ready;
    logic [DCT_BUF_W-1:0]  dct_buffer;
    logic [DCT_CNT_W-1:0]  dct_count;
    logic                  dct_valid;
    logic                  dct_ready;

    modport master (
        output atom_valid, atom, dct_ready,
        input  atom_ready, dct_buffer, dct_count, dct_valid
    );

    modport slave (
        input  atom_valid, atom, dct_ready,
        output atom_ready, dct_buffer, dct_count, dct_valid
    );

endinterface

// File: rtl/lab4_cpu_oci_dct_out_reg.sv
// Single-entry output register holding one packed frame until the consumer takes it.
module lab4_cpu_oci_dct_out_reg
    import lab4_cpu_oci_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [DCT_BUF_W-1:0] load_buffer,
    input  logic [DCT_CNT_W-1:0] load_count,
    input  logic                 dct_ready,
    output logic                 can_load,
    output logic [DCT_BUF_W-1:0] dct_buffer,
    output logic [DCT_CNT_W-1:0] dct_count,
    output logic                 dct_valid
);

    // A new frame may enter when the slot is empty or is being consumed this cycle.
    assign can_load = !dct_valid || dct_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= '0;
            dct_valid  <= 1'b0;
        end else if (load) begin
            dct_buffer <= load_buffer;
            dct_count  <= load_count;
            dct_valid  <= 1'b1;
        end else if (dct_ready) begin
            dct_valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/lab4_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-atom DCT frames with flush and end-of-test drain.
// Optional drop counter enabled by defining LAB4_CPU_OCI_DCT_DROP_CNT_EN.
module lab4_cpu_oci_dct_packer
    import lab4_cpu_oci_dct_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    lab4_cpu_oci_dct_packer_if.slave  bus,
    input  logic                      flush,
    input  logic                      end_req,
    output logic                      test_ending,
    output logic                      test_has_ended
`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
    ,
    output logic [15:0]               drop_count
`endif
);

    localparam logic [DCT_CNT_W-1:0] MAX_CNT = DCT_CNT_W'(DCT_MAX_ATOMS);

    dct_state_e           state;
    logic [DCT_BUF_W-1:0] acc;
    logic [DCT_CNT_W-1:0] cnt;
    logic [DCT_BUF_W-1:0] acc_after;
    logic [DCT_CNT_W-1:0] cnt_after;
    logic [DCT_BUF_W-1:0] acc_n;
    logic [DCT_CNT_W-1:0] cnt_n;
    logic [DCT_BUF_W-1:0] load_buffer;
    logic [DCT_CNT_W-1:0] load_count;
    logic                 active;
    logic                 accept;
    logic                 can_load;
    logic                 load;
    logic                 flush_req;

    assign active         = (state == COLLECT) || (state == STALL);
    assign bus.atom_ready = active && !((cnt == MAX_CNT) && !can_load);
    assign accept         = bus.atom_valid && bus.atom_ready;
    assign acc_after      = accept ? {acc[DCT_BUF_W-DCT_ATOM_W-1:0], bus.atom} : acc;
    assign cnt_after      = accept ? cnt + 4'd1 : cnt;
    assign flush_req      = flush || (state == DRAIN);

    // A full accumulator is emitted before the new atom; otherwise the atom lands first.
    always_comb begin
        load        = 1'b0;
        load_buffer = acc_after;
        load_count  = cnt_after;
        acc_n       = acc_after;
        cnt_n       = cnt_after;
        if (cnt == MAX_CNT) begin
            load_buffer = acc;
            load_count  = cnt;
            if (can_load) begin
                load  = 1'b1;
                acc_n = accept ? {{(DCT_BUF_W-DCT_ATOM_W){1'b0}}, bus.atom} : '0;
                cnt_n = accept ? 4'd1 : 4'd0;
            end
        end else if ((cnt_after == MAX_CNT || flush_req) && cnt_after != '0 && can_load) begin
            load  = 1'b1;
            acc_n = '0;
            cnt_n = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= COLLECT;
            acc            <= '0;
            cnt            <= '0;
            test_ending    <= 1'b0;
            test_has_ended <= 1'b0;
        end else begin
            acc <= acc_n;
            cnt <= cnt_n;
            case (state)
                COLLECT, STALL: begin
                    if (end_req) begin
                        state       <= DRAIN;
                        test_ending <= 1'b1;
                    end else if (cnt_n == MAX_CNT && !load) begin
                        state <= STALL;
                    end else begin
                        state <= COLLECT;
                    end
                end
                DRAIN: begin
                    if (cnt == '0 && can_load) begin
                        state          <= ENDED;
                        test_has_ended <= 1'b1;
                    end
                end
                ENDED: state <= ENDED;
                default: state <= COLLECT;
            endcase
        end
    end

    lab4_cpu_oci_dct_out_reg u_out_reg (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_buffer (load_buffer),
        .load_count  (load_count),
        .dct_ready   (bus.dct_ready),
        .can_load    (can_load),
        .dct_buffer  (bus.dct_buffer),
        .dct_count   (bus.dct_count),
        .dct_valid   (bus.dct_valid)
    );

`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count <= '0;
        end else if (active && bus.atom_valid && !bus.atom_ready && drop_count != 16'hFFFF) begin
            drop_count <= drop_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_lab4_cpu_oci_dct_packer.sv
// Self-checking bench for the DCT packer against a queue-based frame model.
module tb_lab4_cpu_oci_dct_packer;
    import lab4_cpu_oci_dct_pkg::*;

    logic clk;
    logic reset;
    logic flush;
    logic end_req;
    logic test_ending;
    logic test_has_ended;
`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
    logic [15:0] drop_count;
    int          m_drops;
`endif

    lab4_cpu_oci_dct_packer_if bus();

    lab4_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .flush          (flush),
        .end_req        (end_req),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended)
`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_pass;
    int          pend[$];
    logic [33:0] exp_frames[$];
    logic [33:0] got_frames[$];
    bit          m_valid;
    logic [29:0] m_buf;
    logic [3:0]  m_cnt;
    bit          m_ending;
    bit          m_ended;
    bit          exp_ready;
    bit          act_ready;

    // Frame value is the atoms read as base-4 digits, oldest atom most significant.
    function automatic logic [33:0] make_frame();
        longint value;
        int     n;
        value = 0;
        n = pend.size();
        for (int i = 0; i < n; i++) value = value + longint'(pend[i]) * (longint'(4) ** (n - 1 - i));
        return {4'(n), 30'(value)};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.atom_valid = 1'b0;
        bus.atom = 2'b00;
        flush = 1'b0;
        end_req = 1'b0;
        bus.dct_ready = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        pend.delete();
        exp_frames.delete();
        got_frames.delete();
        m_valid = 1'b0;
        m_buf = '0;
        m_cnt = '0;
        m_ending = 1'b0;
        m_ended = 1'b0;
`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
        m_drops = 0;
`endif
    endtask

    task automatic drive(input bit v, input logic [1:0] a, input bit f, input bit e, input bit r);
        bit          room;
        bit          took;
        bit          was_empty;
        bit          emit;
        logic [33:0] frame;
        @(negedge clk);
        bus.atom_valid = v;
        bus.atom = a;
        flush = f;
        end_req = e;
        bus.dct_ready = r;
        #1;
        exp_ready = !m_ending && !(pend.size() == 15 && m_valid && !r);
        act_ready = bus.atom_ready;
        if (bus.dct_valid && r) got_frames.push_back({bus.dct_count, bus.dct_buffer});
        room = !m_valid || r;
        took = v && exp_ready;
        was_empty = (pend.size() == 0);
        emit = 1'b0;
        frame = '0;
        if (m_valid && r) m_valid = 1'b0;
        if (pend.size() == 15) begin
            if (room) begin
                frame = make_frame();
                pend.delete();
                emit = 1'b1;
            end
            if (took) pend.push_back(int'(a));
        end else begin
            if (took) pend.push_back(int'(a));
            if (pend.size() > 0 && room && (pend.size() == 15 || f || m_ending)) begin
                frame = make_frame();
                pend.delete();
                emit = 1'b1;
            end
        end
        if (emit) begin
            m_valid = 1'b1;
            m_cnt = frame[33:30];
            m_buf = frame[29:0];
            exp_frames.push_back(frame);
        end
`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
        if (!m_ending && v && !exp_ready && m_drops != 65535) m_drops++;
`endif
        if (m_ending && !m_ended && was_empty && room) m_ended = 1'b1;
        if (!m_ending && e) m_ending = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (bus.dct_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%0b exp=0", bus.dct_valid); else n_pass++;
        n_checks++; if (bus.dct_buffer !== 30'h0) $display("[TB] FAIL reset_buffer got=%h exp=0", bus.dct_buffer); else n_pass++;
        n_checks++; if (bus.dct_count !== 4'd0) $display("[TB] FAIL reset_count got=%0d exp=0", bus.dct_count); else n_pass++;
        n_checks++; if (bus.atom_ready !== 1'b1) $display("[TB] FAIL reset_ready got=%0b exp=1", bus.atom_ready); else n_pass++;
        n_checks++; if (test_ending !== 1'b0) $display("[TB] FAIL reset_ending got=%0b exp=0", test_ending); else n_pass++;
        n_checks++; if (test_has_ended !== 1'b0) $display("[TB] FAIL reset_ended got=%0b exp=0", test_has_ended); else n_pass++;
`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
        n_checks++; if (drop_count !== 16'd0) $display("[TB] FAIL reset_drops got=%0d exp=0", drop_count); else n_pass++;
`endif
    endtask

    task automatic test_full_frame();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
            n_checks++; if (bus.dct_valid !== (i == 14)) $display("[TB] FAIL full_valid[%0d] got=%0b exp=%0b", i, bus.dct_valid, i == 14); else n_pass++;
        end
        n_checks++; if (bus.dct_buffer !== 30'h15555555) $display("[TB] FAIL full_buffer got=%h exp=15555555", bus.dct_buffer); else n_pass++;
        n_checks++; if (bus.dct_count !== 4'd15) $display("[TB] FAIL full_count got=%0d exp=15", bus.dct_count); else n_pass++;
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.dct_valid !== 1'b0) $display("[TB] FAIL full_consumed got=%0b exp=0", bus.dct_valid); else n_pass++;
        n_checks++; if (got_frames.size() !== 1) $display("[TB] FAIL full_handshakes got=%0d exp=1", got_frames.size()); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.dct_valid !== 1'b0) $display("[TB] FAIL flush_early got=%0b exp=0", bus.dct_valid); else n_pass++;
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (bus.dct_valid !== 1'b1) $display("[TB] FAIL flush_valid got=%0b exp=1", bus.dct_valid); else n_pass++;
        n_checks++; if (bus.dct_buffer !== 30'h39) $display("[TB] FAIL flush_buffer got=%h exp=39", bus.dct_buffer); else n_pass++;
        n_checks++; if (bus.dct_count !== 4'd3) $display("[TB] FAIL flush_count got=%0d exp=3", bus.dct_count); else n_pass++;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.dct_valid !== 1'b0) $display("[TB] FAIL flush_empty got=%0b exp=0", bus.dct_valid); else n_pass++;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (bus.dct_valid !== 1'b0) $display("[TB] FAIL flush_empty_late got=%0b exp=0", bus.dct_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
            n_checks++; if (act_ready !== 1'b1) $display("[TB] FAIL b2b_ready[%0d] got=%0b exp=1", i, act_ready); else n_pass++;
            if (i >= 14) begin
                n_checks++;
                if ({bus.dct_valid, bus.dct_count, bus.dct_buffer} !== {1'b1, exp_frames[0]})
                    $display("[TB] FAIL b2b_hold[%0d] got=%0b/%h exp=1/%h", i, bus.dct_valid, {bus.dct_count, bus.dct_buffer}, exp_frames[0]);
                else n_pass++;
            end
        end
        drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        n_checks++; if (act_ready !== 1'b0) $display("[TB] FAIL b2b_31st_ready got=%0b exp=0", act_ready); else n_pass++;
        for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (got_frames.size() !== 2) $display("[TB] FAIL b2b_frames got=%0d exp=2", got_frames.size()); else n_pass++;
        for (int k = 0; k < 2 && k < got_frames.size(); k++) begin
            n_checks++; if (got_frames[k] !== exp_frames[k]) $display("[TB] FAIL b2b_frame[%0d] got=%h exp=%h", k, got_frames[k], exp_frames[k]); else n_pass++;
            n_checks++; if (got_frames[k][33:30] !== 4'd15) $display("[TB] FAIL b2b_count[%0d] got=%0d exp=15", k, got_frames[k][33:30]); else n_pass++;
        end
    endtask

    task automatic test_restart();
        do_reset();
        for (int i = 0; i < 30; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        n_checks++; if (act_ready !== 1'b1) $display("[TB] FAIL restart_ready got=%0b exp=1", act_ready); else n_pass++;
        drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (bus.dct_valid !== 1'b1) $display("[TB] FAIL restart_valid got=%0b exp=1", bus.dct_valid); else n_pass++;
        n_checks++; if (bus.dct_count !== 4'd1) $display("[TB] FAIL restart_count got=%0d exp=1", bus.dct_count); else n_pass++;
        n_checks++; if (bus.dct_buffer !== 30'h2) $display("[TB] FAIL restart_buffer got=%h exp=2", bus.dct_buffer); else n_pass++;
        n_checks++; if (got_frames.size() !== 2) $display("[TB] FAIL restart_frames got=%0d exp=2", got_frames.size()); else n_pass++;
        if (got_frames.size() == 2) begin
            n_checks++; if (got_frames[1] !== exp_frames[1]) $display("[TB] FAIL restart_second got=%h exp=%h", got_frames[1], exp_frames[1]); else n_pass++;
        end
    endtask

    task automatic test_end_of_test();
        do_reset();
        for (int i = 0; i < 20; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (test_ending !== 1'b1) $display("[TB] FAIL end_ending got=%0b exp=1", test_ending); else n_pass++;
        n_checks++; if (test_has_ended !== 1'b0) $display("[TB] FAIL end_early got=%0b exp=0", test_has_ended); else n_pass++;
        drive(1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        n_checks++; if (act_ready !== 1'b0) $display("[TB] FAIL end_ready got=%0b exp=0", act_ready); else n_pass++;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (test_has_ended !== 1'b0) $display("[TB] FAIL end_after_one got=%0b exp=0", test_has_ended); else n_pass++;
        drive(1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        n_checks++; if (test_has_ended !== 1'b1) $display("[TB] FAIL end_ended got=%0b exp=1", test_has_ended); else n_pass++;
        n_checks++; if (got_frames.size() !== 2) $display("[TB] FAIL end_frames got=%0d exp=2", got_frames.size()); else n_pass++;
        if (got_frames.size() == 2) begin
            n_checks++; if (got_frames[1] !== exp_frames[1]) $display("[TB] FAIL end_partial got=%h exp=%h", got_frames[1], exp_frames[1]); else n_pass++;
            n_checks++; if (got_frames[1][33:30] !== 4'd5) $display("[TB] FAIL end_partial_count got=%0d exp=5", got_frames[1][33:30]); else n_pass++;
        end
        for (int i = 0; i < 3; i++) drive(1'b1, 2'd2, 1'b1, 1'b0, 1'b1);
        n_checks++; if ({test_ending, test_has_ended, bus.dct_valid} !== 3'b110) $display("[TB] FAIL end_held got=%b exp=110", {test_ending, test_has_ended, bus.dct_valid}); else n_pass++;
    endtask

    task automatic test_random();
        int budget;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0, 1'b0, 1'($urandom_range(0, 1)));
            n_checks++; if (act_ready !== exp_ready) $display("[TB] FAIL rnd_ready[%0d] got=%0b exp=%0b", i, act_ready, exp_ready); else n_pass++;
            n_checks++; if (bus.dct_valid !== m_valid) $display("[TB] FAIL rnd_valid[%0d] got=%0b exp=%0b", i, bus.dct_valid, m_valid); else n_pass++;
            if (m_valid) begin
                n_checks++; if ({bus.dct_count, bus.dct_buffer} !== {m_cnt, m_buf}) $display("[TB] FAIL rnd_frame[%0d] got=%h exp=%h", i, {bus.dct_count, bus.dct_buffer}, {m_cnt, m_buf}); else n_pass++;
            end
        end
        budget = 0;
        while (!test_has_ended && budget < 40) begin
            drive(1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
            budget++;
        end
        n_checks++; if (test_has_ended !== 1'b1) $display("[TB] FAIL rnd_drain_timeout got=%0b exp=1", test_has_ended); else n_pass++;
        n_checks++; if (got_frames.size() !== exp_frames.size()) $display("[TB] FAIL rnd_frame_total got=%0d exp=%0d", got_frames.size(), exp_frames.size()); else n_pass++;
        for (int k = 0; k < got_frames.size() && k < exp_frames.size(); k++) begin
            n_checks++; if (got_frames[k] !== exp_frames[k]) $display("[TB] FAIL rnd_order[%0d] got=%h exp=%h", k, got_frames[k], exp_frames[k]); else n_pass++;
        end
    endtask

    task automatic test_midframe_reset();
        do_reset();
        for (int i = 0; i < 30; i++) drive(1'b1, 2'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
        n_checks++; if (drop_count !== 16'd3) $display("[TB] FAIL drops got=%0d exp=3", drop_count); else n_pass++;
`endif
        do_reset();
        n_checks++; if ({bus.dct_valid, bus.dct_count, bus.dct_buffer} !== 35'h0) $display("[TB] FAIL mid_reset_out got=%h exp=0", {bus.dct_valid, bus.dct_count, bus.dct_buffer}); else n_pass++;
        n_checks++; if ({bus.atom_ready, test_ending, test_has_ended} !== 3'b100) $display("[TB] FAIL mid_reset_flags got=%b exp=100", {bus.atom_ready, test_ending, test_has_ended}); else n_pass++;
`ifdef LAB4_CPU_OCI_DCT_DROP_CNT_EN
        n_checks++; if (drop_count !== 16'd0) $display("[TB] FAIL mid_reset_drops got=%0d exp=0", drop_count); else n_pass++;
`endif
        for (int i = 0; i < 5; i++) drive(1'b0, 2'd0, 1'b1, 1'b0, 1'b1);
        n_checks++; if (got_frames.size() !== 0) $display("[TB] FAIL mid_reset_stale got=%0d exp=0", got_frames.size()); else n_pass++;
        n_checks++; if (bus.dct_valid !== 1'b0) $display("[TB] FAIL mid_reset_valid got=%0b exp=0", bus.dct_valid); else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        n_checks = 0;
        n_pass = 0;
        reset = 1'b1;
        flush = 1'b0;
        end_req = 1'b0;
        bus.atom_valid = 1'b0;
        bus.atom = 2'b00;
        bus.dct_ready = 1'b0;
        test_reset();
        test_full_frame();
        test_flush();
        test_back_to_back();
        test_restart();
        test_end_of_test();
        test_random();
        test_midframe_reset();
        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
